// File: rtl/conv_window_sequencer.sv
// Purpose : raster pixel stream -> 4 line buffers + 5x5 window -> external conv core -> registered result.
// Latency : 2 cycles from the accept of a window's bottom-right pixel to res_valid (win_vld, then result register).
// Backpressure: res_ready low with a result held stalls the window stage, which drops pix_ready.
//
// Ports: clk/rst_n (sync, active low); start begins a frame from IDLE; pix_in/pix_valid/pix_ready
// is the pixel handshake; win_out drives the core, conv_result returns from it combinationally;
// res_out/res_valid/res_ready is the result handshake; busy/done report frame progress;
// stall_cnt counts output-stall cycles when built with CONV_SEQ_PERF_EN, otherwise reads 0.
module conv_window_sequencer #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [199:0] win_out,
    input  logic [63:0]  conv_result,
    output logic [63:0]  res_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  stall_cnt
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FOUR = CW'(4);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FOUR = RW'(4);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            win_vld;
    logic [199:0]    win_q;
    logic [199:0]    win_shift;
    logic [63:0]     res_q;
    logic            res_vld_q;
    logic [7:0]      lb [0:3][0:IMG_W-1];
    logic [7:0]      new_col [0:4];

    logic adv;
    logic accept;
    logic last_pix;
    logic frame_start;
    logic load_res;

    assign adv         = !res_vld_q || res_ready;
    assign accept      = pix_valid && pix_ready;
    assign last_pix    = (row == ROW_LAST) && (col == COL_LAST);
    assign frame_start = (state == S_IDLE) && start;
    assign load_res    = win_vld && adv;

    assign win_out   = win_q;
    assign res_out   = res_q;
    assign res_valid = res_vld_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
            S_DRAIN: if (!win_vld && !res_vld_q) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A pixel may enter when the window stage is empty or will be drained this cycle.
    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                pix_ready = adv || !win_vld;
                busy      = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- window column build ----------------
    // Row 0 of the window is the oldest line, so the oldest buffer tap goes on top.
    always_comb begin
        new_col[0] = lb[0][col];
        new_col[1] = lb[1][col];
        new_col[2] = lb[2][col];
        new_col[3] = lb[3][col];
        new_col[4] = pix_in;
    end

    always_comb begin
        win_shift = win_q;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_shift[8*(5*r+c) +: 8] = win_q[8*(5*r+c+1) +: 8];
            end
            win_shift[8*(5*r+4) +: 8] = new_col[r];
        end
    end

    // Line buffers hold no reset: every entry is rewritten by four full rows before any
    // window containing it is flagged valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= lb[1][col];
            lb[1][col] <= lb[2][col];
            lb[2][col] <= lb[3][col];
            lb[3][col] <= pix_in;
        end
    end

    // ---------------- position, window and result stages ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            win_vld   <= 1'b0;
            win_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else if (frame_start) begin
            row       <= '0;
            col       <= '0;
            win_vld   <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            if (accept) begin
                win_q   <= win_shift;
                win_vld <= (row >= ROW_FOUR) && (col >= COL_FOUR);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (load_res) begin
                win_vld <= 1'b0;
            end

            // Load wins over consumer accept, so back-to-back results have no bubble.
            if (load_res) begin
                res_q     <= conv_result;
                res_vld_q <= 1'b1;
            end else if (res_ready) begin
                res_vld_q <= 1'b0;
            end
        end
    end

    // ---------------- optional output-stall counter ----------------
`ifdef CONV_SEQ_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (frame_start) begin
            stall_q <= '0;
        end else if (busy && res_vld_q && !res_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a 5x5 and an 8x8 instance share clock and reset.
// A behavioural conv core answers win_out; results are compared against windows computed
// directly from the frame image held in the bench.
module tb_conv_window_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start     [2];
    logic [7:0]   pix_in    [2];
    logic         pix_valid [2];
    logic         res_ready [2];
    wire          pix_ready [2];
    wire  [199:0] win_out   [2];
    wire  [63:0]  conv_result [2];
    wire  [63:0]  res_out   [2];
    wire          res_valid [2];
    wire          busy      [2];
    wire          done      [2];
    wire  [31:0]  stall_cnt [2];

`ifdef CONV_SEQ_PERF_EN
    localparam int EXP_STALL = 20;
`else
    localparam int EXP_STALL = 0;
`endif
    localparam logic [63:0] ONES_RES = 64'h00D9_00D0_00C7_00BE;

    conv_window_sequencer #(.IMG_W(5), .IMG_H(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .pix_in(pix_in[0]),
        .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .win_out(win_out[0]),
        .conv_result(conv_result[0]), .res_out(res_out[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .busy(busy[0]), .done(done[0]), .stall_cnt(stall_cnt[0])
    );

    conv_window_sequencer #(.IMG_W(8), .IMG_H(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .pix_in(pix_in[1]),
        .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .win_out(win_out[1]),
        .conv_result(conv_result[1]), .res_out(res_out[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .busy(busy[1]), .done(done[1]), .stall_cnt(stall_cnt[1])
    );

    // Core weights: channel k sums to 190 + 9k, giving 190/199/208/217 for an all-ones window.
    function automatic int wt(input int k, input int i);
        return 6 + (i % 3) + ((i == 12) ? (16 + 9 * k) : 0);
    endfunction

    function automatic logic [63:0] core(input logic [199:0] w);
        logic [63:0] r;
        int acc;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int i = 0; i < 25; i++) acc += wt(k, i) * int'(w[8*i +: 8]);
            r[16*k +: 16] = 16'(acc);
        end
        return r;
    endfunction

    assign conv_result[0] = core(win_out[0]);
    assign conv_result[1] = core(win_out[1]);

    int img [64];

    // Reference: window whose bottom-right pixel is (r, c) in a frame of width wd.
    function automatic logic [63:0] ref_res(input int wd, input int r, input int c);
        logic [63:0] v;
        int acc;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int dr = 0; dr < 5; dr++)
                for (int dc = 0; dc < 5; dc++)
                    acc += wt(k, 5*dr + dc) * img[(r - 4 + dr) * wd + (c - 4 + dc)];
            v[16*k +: 16] = 16'(acc);
        end
        return v;
    endfunction

    int tests = 0;
    int fails = 0;

    logic [63:0] got_q [$];
    logic [63:0] exp_q [$];
    int acc_cyc [64];
    int first_rv, done_cnt, bd_bad, hold_viol, stall_prdy, timeout_f, cyc;

    task automatic build_expected(input int d);
        int wd;
        wd = (d == 1) ? 8 : 5;
        exp_q.delete();
        for (int r = 4; r < wd; r++)
            for (int c = 4; c < wd; c++) exp_q.push_back(ref_res(wd, r, c));
    endtask

    // Drives one frame into instance d and records observations; rmode 0 = ready high,
    // 1 = random ready, 2 = 20 ready-low cycles right after the first result.
    // abort_idx >= 0 asserts reset once that many pixels were accepted (left asserted).
    task automatic run_frame(input int d, input int gaps, input int rmode,
                             input int start_mid, input int abort_idx);
        int np, idx, after;
        logic prev_stall, prev_busy, in_stall;
        logic [63:0] prev_out;
        np = (d == 1) ? 64 : 25;
        got_q.delete();
        first_rv = -1; done_cnt = 0; bd_bad = 0; hold_viol = 0; stall_prdy = 0;
        timeout_f = 0; cyc = 0; idx = 0; after = -1;
        prev_stall = 1'b0; prev_busy = 1'b0; prev_out = '0;
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            in_stall = (rmode == 2) && (first_rv >= 0) && (cyc > first_rv) && (cyc <= first_rv + 20);
            pix_valid[d] = (idx < np) && ((gaps == 0) || ($urandom_range(0, 3) != 0));
            pix_in[d]    = 8'(img[(idx < np) ? idx : 0]);
            res_ready[d] = (rmode == 1) ? ($urandom_range(0, 2) != 0) : !in_stall;
            start[d]     = (start_mid != 0) && (cyc == 10);
            #1;
            if (prev_stall && (!res_valid[d] || res_out[d] !== prev_out)) hold_viol++;
            prev_stall = res_valid[d] && !res_ready[d];
            prev_out   = res_out[d];
            if (in_stall && pix_ready[d]) stall_prdy++;
            if (pix_valid[d] && pix_ready[d]) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (res_valid[d] && first_rv < 0) first_rv = cyc;
            if (res_valid[d] && res_ready[d]) got_q.push_back(res_out[d]);
            if (done[d]) begin
                done_cnt++;
                if (busy[d] || !prev_busy) bd_bad++;
                if (after < 0) after = 3;
            end
            prev_busy = busy[d];
            if (after >= 0) begin
                if (after == 0) break;
                after--;
            end
            if (abort_idx >= 0 && idx >= abort_idx) begin
                rst_n = 1'b0;
                break;
            end
            if (cyc > 3000) begin
                timeout_f = 1;
                break;
            end
        end
        pix_valid[d] = 1'b0;
        start[d]     = 1'b0;
        res_ready[d] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++; if (pix_ready[d] !== 1'b0) begin fails++; $display("FAIL reset_pix_ready[%0d]: got %b want 0", d, pix_ready[d]); end
            tests++; if (res_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_res_valid[%0d]: got %b want 0", d, res_valid[d]); end
            tests++; if (res_out[d] !== 64'h0) begin fails++; $display("FAIL reset_res_out[%0d]: got %h want 0", d, res_out[d]); end
            tests++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
            tests++; if (done[d] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b want 0", d, done[d]); end
            tests++; if (stall_cnt[d] !== 32'h0) begin fails++; $display("FAIL reset_stall_cnt[%0d]: got %0d want 0", d, stall_cnt[d]); end
            tests++; if (win_out[d] !== 200'h0) begin fails++; $display("FAIL reset_win_out[%0d]: got %h want 0", d, win_out[d]); end
        end
        @(negedge clk); rst_n = 1'b1;
        // Source offers data while IDLE: nothing may be taken.
        pix_valid[1] = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            tests++; if (pix_ready[1] !== 1'b0) begin fails++; $display("FAIL idle_pix_ready: got %b want 0", pix_ready[1]); end
        end
        pix_valid[1] = 1'b0;
    endtask

    task automatic test_ones_5x5();
        for (int i = 0; i < 64; i++) img[i] = 1;
        run_frame(0, 0, 0, 0, -1);
        tests++; if (timeout_f !== 0) begin fails++; $display("FAIL ones5_timeout: got %0d want 0", timeout_f); end
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL ones5_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests++; if (got_q[0] !== ONES_RES) begin fails++; $display("FAIL ones5_value: got %h want %h", got_q[0], ONES_RES); end
        end
        tests++; if (first_rv - acc_cyc[24] !== 2) begin fails++; $display("FAIL ones5_latency: got %0d want 2", first_rv - acc_cyc[24]); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL ones5_done_pulses: got %0d want 1", done_cnt); end
        tests++; if (bd_bad !== 0) begin fails++; $display("FAIL ones5_busy_done: got %0d want 0", bd_bad); end
    endtask

    task automatic test_raster_8x8();
        for (int i = 0; i < 64; i++) img[i] = i;
        build_expected(1);
        run_frame(1, 1, 0, 0, -1);
        tests++; if (got_q.size() !== 16) begin fails++; $display("FAIL raster_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL raster_res[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (first_rv - acc_cyc[36] !== 2) begin fails++; $display("FAIL raster_first_latency: got %0d want 2", first_rv - acc_cyc[36]); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL raster_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(0, 255));
        build_expected(1);
        run_frame(1, 0, 2, 0, -1);
        tests++; if (got_q.size() !== 16) begin fails++; $display("FAIL bp_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_res[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (hold_viol !== 0) begin fails++; $display("FAIL bp_hold: got %0d changes want 0", hold_viol); end
        tests++; if (stall_prdy !== 0) begin fails++; $display("FAIL bp_pix_ready_stall: got %0d ready cycles want 0", stall_prdy); end
        tests++; if (stall_cnt[1] !== 32'(EXP_STALL)) begin fails++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt[1], EXP_STALL); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(0, 255));
        build_expected(1);
        run_frame(1, 1, 1, 0, -1);
        tests++; if (got_q.size() !== 16) begin fails++; $display("FAIL rand_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_res[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (hold_viol !== 0) begin fails++; $display("FAIL rand_hold: got %0d changes want 0", hold_viol); end
        tests++; if (bd_bad !== 0) begin fails++; $display("FAIL rand_busy_done: got %0d want 0", bd_bad); end
    endtask

    task automatic test_max_pixels();
        for (int i = 0; i < 64; i++) img[i] = 255;
        build_expected(0);
        run_frame(0, 1, 1, 0, -1);
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL max_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests++; if (got_q[0][15:0] !== 16'hBD42) begin fails++; $display("FAIL max_ch0: got %h want bd42", got_q[0][15:0]); end
            tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL max_value: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(1, 1, 1, 0, 50);
        @(negedge clk); #1;
        tests++; if (res_valid[1] !== 1'b0) begin fails++; $display("FAIL midrst_res_valid: got %b want 0", res_valid[1]); end
        tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy[1]); end
        tests++; if (pix_ready[1] !== 1'b0) begin fails++; $display("FAIL midrst_pix_ready: got %b want 0", pix_ready[1]); end
        tests++; if (res_out[1] !== 64'h0) begin fails++; $display("FAIL midrst_res_out: got %h want 0", res_out[1]); end
        tests++; if (win_out[1] !== 200'h0) begin fails++; $display("FAIL midrst_win_out: got %h want 0", win_out[1]); end
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) img[i] = 1;
        // start pulsed during RUN must not restart the frame
        run_frame(0, 0, 0, 1, -1);
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL midrst5_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests++; if (got_q[0] !== ONES_RES) begin fails++; $display("FAIL midrst5_value: got %h want %h", got_q[0], ONES_RES); end
        end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL midrst5_done_pulses: got %0d want 1", done_cnt); end
        run_frame(1, 0, 0, 0, -1);
        tests++; if (got_q.size() !== 16) begin fails++; $display("FAIL midrst8_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== ONES_RES) begin fails++; $display("FAIL midrst8_res[%0d]: got %h want %h", i, got_q[i], ONES_RES); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; pix_in[d] = 8'h0; pix_valid[d] = 1'b0; res_ready[d] = 1'b1;
        end
        test_reset();
        test_ones_5x5();
        test_raster_8x8();
        test_backpressure();
        test_random_traffic();
        test_max_pixels();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
